uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte producers using round-robin arbitration.
- Accepts one byte per grant over a valid/ready handshake.
- Drives the transmitter's start and data_in, and tracks its busy flag until the frame completes.
- Sits between the producers and uart_tx, in the system clock domain; uart_tx runs on the baud clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_W, 8, byte width; must equal the uart_tx data width.
TIMEOUT_CYCLES, 4096, clk cycles to wait for tx_busy to rise (used only with the optional feature).

Ports:
clk  input  1  system clock.
srst  input  1  synchronous active-high reset.
req_valid  input  NUM_REQ  per-requester byte-pending flag.
req_data  input  NUM_REQ*DATA_W  packed bytes; requester i uses bits [i*DATA_W +: DATA_W].
req_ready  output  NUM_REQ  one-hot acceptance pulse.
tx_start  output  1  start request to uart_tx.
tx_data  output  DATA_W  byte to uart_tx data_in.
tx_busy  input  1  uart_tx busy flag (baud-clock domain, slow-changing).
grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
active  output  1  high from acceptance until the frame completes.
err_timeout  output  1  one-cycle pulse on watchdog abort (optional feature only; otherwise tied 0).

Behaviour:
- Clock and reset: single clock clk; reset srst is synchronous and active-high.
- tx_busy handling: passed through a 2-flop synchroniser internally; all references below mean the synchronised value.
- Reset values: state=IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, err_timeout=0, rr_ptr=0.
- Reset mid-operation: returns to IDLE immediately. No byte is accepted in the reset cycle. A frame already inside uart_tx is not cancelled.
- IDLE:
  - If any req_valid is high, the winner is the first valid index searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Same cycle (registered at the edge): req_ready[winner]=1 for exactly one cycle, tx_data<=req_data[winner], grant_id<=winner, active<=1, go to LAUNCH.
  - If no req_valid is high, stay in IDLE.
- LAUNCH:
  - tx_start=1; tx_data is held stable.
  - Stay until tx_busy=1, then tx_start<=0 and go to WAIT_DONE.
  - tx_start stays high across multiple baud periods by design, so the slow clk_t domain samples it.
- WAIT_DONE:
  - Wait for tx_busy=0, then active<=0, rr_ptr<=(grant_id+1) mod NUM_REQ, go to IDLE.
- Latency: acceptance to tx_start rising = 1 cycle. Back-to-back frames have at least 1 IDLE cycle between them.
- Data sampling: requester data is sampled only in the acceptance cycle; later changes to req_data are ignored.
- Requester rules: a requester must hold req_valid until it sees req_ready. Dropping req_valid without ready is allowed, and that requester is simply not granted.
- Simultaneous requests: only one grant per arbitration. The others keep waiting; no requester is starved, with a worst-case wait of NUM_REQ-1 frames.
- Single active requester: granted repeatedly, with rr_ptr advancing past it each time.
- rr_ptr wrap: NUM_REQ-1 -> 0.
- tx_busy already high on entry to LAUNCH (stale frame): counts as acknowledged, go to WAIT_DONE.
- Invariants: no new acceptance while active=1; req_ready is never high outside the IDLE->LAUNCH transition.

Optional Feature:
UART_ARB_TIMEOUT_EN:
- Defined: a counter runs in LAUNCH. If tx_busy has not risen after TIMEOUT_CYCLES cycles:
  - tx_start<=0, active<=0, err_timeout pulses for 1 cycle, rr_ptr advances, go to IDLE; the byte is dropped.
  - The counter clears on every entry to LAUNCH and on srst.
- Undefined: no counter; LAUNCH waits indefinitely; err_timeout is constant 0.

Test Plan:
1. Reset with req_valid=4'b0101 held -> all outputs 0 during srst; first cycle after release grants req 0 (req_ready=0001), tx_data=req_data[0]=8'hA5.
2. req_valid=4'b1111 constant, bytes 8'h10/8'h21/8'h32/8'h43 -> grant order 0,1,2,3,0; each req_ready a single one-cycle pulse; tx_data matches the byte per grant.
3. Only req 2 valid repeatedly with 8'h3C -> three consecutive frames, all grant_id=2; active low for at least 1 cycle between frames; tx_start held until tx_busy rises.
4. Requester changes req_data from 8'h55 to 8'hAA the cycle after req_ready -> tx_data stays 8'h55 through the frame.
5. srst asserted while in WAIT_DONE -> next cycle state IDLE, active=0, tx_start=0, rr_ptr=0; a pending req_valid[3] is granted after srst deasserts.
6. With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, tx_busy tied 0 -> tx_start high for 16 cycles, then err_timeout pulses once, active=0, next requester granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// Optional launch watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_start,
    output logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          active,
    output logic                          err_timeout
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

    state_t             state;
    logic               busy_meta;
    logic               busy_sync;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   next_ptr;
    logic               any_valid;
    logic [DATA_W-1:0]  req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
    end

    // First valid requester searching upward from rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!any_valid && req_valid[IDX_W'(idx)]) begin
                any_valid = 1'b1;
                winner    = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        next_ptr = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] to_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            req_ready <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            grant_id  <= '0;
            active    <= 1'b0;
            rr_ptr    <= '0;
            busy_meta <= 1'b0;
            busy_sync <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err_timeout <= 1'b0;
            to_cnt      <= '0;
`endif
        end else begin
            busy_meta <= tx_busy;
            busy_sync <= busy_meta;
            req_ready <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        req_ready[winner] <= 1'b1;
                        tx_data           <= req_bytes[winner];
                        grant_id          <= winner;
                        active            <= 1'b1;
                        tx_start          <= 1'b1;
                        state             <= LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
                        to_cnt            <= '0;
`endif
                    end
                end
                LAUNCH: begin
                    // A stale busy from an earlier frame also counts as acknowledgement.
                    if (busy_sync) begin
                        tx_start <= 1'b0;
                        state    <= WAIT_DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        tx_start    <= 1'b0;
                        active      <= 1'b0;
                        err_timeout <= 1'b1;
                        rr_ptr      <= next_ptr;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!busy_sync) begin
                        active <= 1'b0;
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit data).
// Watchdog steps run only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
    logic        clk;
    logic        srst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        err_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_W(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .srst(srst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .active(active),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered just after the acceptance edge; returns just after the edge back to IDLE.
    task automatic frame(input int id, input logic [7:0] d, input bit drop, input bit scramble);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        chk("accept_ready", {28'd0, req_ready}, {28'd0, oh});
        chk("accept_data", {24'd0, tx_data}, {24'd0, d});
        chk("accept_grant", {30'd0, grant_id}, id);
        chk("accept_active", {31'd0, active}, 1);
        chk("accept_start", {31'd0, tx_start}, 1);
        chk("accept_err", {31'd0, err_timeout}, 0);
        if (drop) req_valid[id] = 1'b0;
        if (scramble) req_data[id*8 +: 8] = ~d;
        tick();
        chk("ready_pulse_end", {28'd0, req_ready}, 0);
        chk("launch_start", {31'd0, tx_start}, 1);
        tx_busy = 1'b1;
        tick();
        tick();
        chk("start_hold", {31'd0, tx_start}, 1);
        chk("launch_data", {24'd0, tx_data}, {24'd0, d});
        tick();
        chk("start_drop", {31'd0, tx_start}, 0);
        chk("wait_active", {31'd0, active}, 1);
        chk("wait_data", {24'd0, tx_data}, {24'd0, d});
        tx_busy = 1'b0;
        tick();
        tick();
        chk("wait_hold", {31'd0, active}, 1);
        tick();
        chk("done_active", {31'd0, active}, 0);
        chk("done_ready", {28'd0, req_ready}, 0);
        chk("done_err", {31'd0, err_timeout}, 0);
    endtask

    initial begin
        // Reset with requests pending: outputs stay zero.
        srst      = 1'b1;
        tx_busy   = 1'b0;
        req_valid = 4'b0101;
        req_data  = {8'h00, 8'h5A, 8'h00, 8'hA5};
        tick();
        tick();
        chk("rst_ready", {28'd0, req_ready}, 0);
        chk("rst_start", {31'd0, tx_start}, 0);
        chk("rst_data", {24'd0, tx_data}, 0);
        chk("rst_grant", {30'd0, grant_id}, 0);
        chk("rst_active", {31'd0, active}, 0);
        chk("rst_err", {31'd0, err_timeout}, 0);
        srst = 1'b0;
        tick();
        frame(0, 8'hA5, 1'b1, 1'b0);
        tick();
        frame(2, 8'h5A, 1'b1, 1'b0);

        // All four requesting: grant order 0,1,2,3,0.
        srst = 1'b1;
        tick();
        srst      = 1'b0;
        req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
        req_valid = 4'b1111;
        tick();
        frame(0, 8'h10, 1'b0, 1'b0);
        tick();
        frame(1, 8'h21, 1'b0, 1'b0);
        tick();
        frame(2, 8'h32, 1'b0, 1'b0);
        tick();
        frame(3, 8'h43, 1'b0, 1'b0);
        tick();
        frame(0, 8'h10, 1'b0, 1'b0);
        req_valid = 4'b0000;

        // Single requester granted repeatedly.
        req_data[23:16] = 8'h3C;
        req_valid       = 4'b0100;
        tick();
        frame(2, 8'h3C, 1'b0, 1'b0);
        tick();
        frame(2, 8'h3C, 1'b0, 1'b0);
        tick();
        frame(2, 8'h3C, 1'b1, 1'b0);

        // Data changed after acceptance is ignored.
        req_data[7:0] = 8'h55;
        req_valid     = 4'b0001;
        tick();
        frame(0, 8'h55, 1'b1, 1'b1);

        // Reset while in WAIT_DONE.
        req_data[23:16] = 8'h77;
        req_valid       = 4'b0100;
        tick();
        chk("pre_rst_ready", {28'd0, req_ready}, 32'h4);
        req_valid = 4'b0000;
        tx_busy   = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_wait", {31'd0, tx_start}, 0);
        req_data[31:24] = 8'hC3;
        req_valid       = 4'b1000;
        srst            = 1'b1;
        tx_busy         = 1'b0;
        tick();
        chk("midrst_active", {31'd0, active}, 0);
        chk("midrst_start", {31'd0, tx_start}, 0);
        chk("midrst_grant", {30'd0, grant_id}, 0);
        chk("midrst_data", {24'd0, tx_data}, 0);
        tick();
        chk("midrst_noaccept", {28'd0, req_ready}, 0);
        srst = 1'b0;
        tick();
        frame(3, 8'hC3, 1'b0, 1'b0);

        // Pointer wrapped 3 -> 0: requester 0 beats 3.
        req_data[7:0] = 8'hE1;
        req_valid     = 4'b1001;
        tick();
        frame(0, 8'hE1, 1'b1, 1'b0);
        tick();
        frame(3, 8'hC3, 1'b1, 1'b0);

`ifdef UART_ARB_TIMEOUT_EN
        // tx_busy never rises: abort after 16 launch cycles, next requester served.
        req_data[7:0]  = 8'h11;
        req_data[15:8] = 8'h22;
        req_valid      = 4'b0011;
        tick();
        chk("to_accept", {28'd0, req_ready}, 32'h1);
        req_valid[0] = 1'b0;
        chk("to_start_0", {31'd0, tx_start}, 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to_start_hold", {31'd0, tx_start}, 1);
            chk("to_err_quiet", {31'd0, err_timeout}, 0);
        end
        tick();
        chk("to_err_pulse", {31'd0, err_timeout}, 1);
        chk("to_start_drop", {31'd0, tx_start}, 0);
        chk("to_active", {31'd0, active}, 0);
        tick();
        chk("to_err_once", {31'd0, err_timeout}, 0);
        frame(1, 8'h22, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
